// File: rtl/ecg_pkg.sv
// Shared types and width helpers for the Pan-Tompkins feature stage.
package ecg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DERIV,
        SQUARE,
        INTEG,
        OUT
    } fsm_state_e;

    localparam int DERIV_SHIFT  = 3;
    localparam int DATA_W_DEF   = 16;
    localparam int WIN_LOG2_DEF = 5;

    // Squared derivative: |d| < 2**(DATA_W-2) keeps d*d within 2*DATA_W-2 bits.
    function automatic int sq_w_of(input int data_w);
        return 2 * data_w - 2;
    endfunction

    function automatic int acc_w_of(input int data_w, input int win_log2);
        return sq_w_of(data_w) + win_log2;
    endfunction

endpackage

// File: rtl/mwi_ring_buf.sv
// Moving-window history of squared samples; exposes the oldest entry, which is
// overwritten by the newest one on each write.
module mwi_ring_buf #(
    parameter int WIDTH      = 30,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_oldest
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wptr;

    assign o_oldest = r_mem[r_wptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr <= '0;
        end else if (i_we) begin
            r_mem[r_wptr] <= i_wdata;
            r_wptr        <= r_wptr + 1'b1;
        end
    end

endmodule

// File: rtl/ecg_qrs_feature_axis.sv
// Pan-Tompkins feature stage: 5-point derivative, square and moving-window
// integral over AXI-Stream, one sample in flight at a time.
module ecg_qrs_feature_axis
    import ecg_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int WIN_LOG2 = WIN_LOG2_DEF,
    parameter int OUT_W    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    output logic [OUT_W-1:0]         m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready
);

    localparam int W_SQ  = sq_w_of(DATA_W);
    localparam int W_ACC = acc_w_of(DATA_W, WIN_LOG2);
    localparam int W_SUM = DATA_W + 3;

    // Floor of (2*x0 + x1 - x3 - 2*x4) / 8; the sum never exceeds 6*2**(DATA_W-1).
    function automatic logic signed [DATA_W-1:0] deriv5(
        input logic signed [DATA_W-1:0] a0,
        input logic signed [DATA_W-1:0] a1,
        input logic signed [DATA_W-1:0] a3,
        input logic signed [DATA_W-1:0] a4
    );
        logic signed [W_SUM-1:0] e0, e1, e3, e4, s;
        e0 = {{3{a0[DATA_W-1]}}, a0};
        e1 = {{3{a1[DATA_W-1]}}, a1};
        e3 = {{3{a3[DATA_W-1]}}, a3};
        e4 = {{3{a4[DATA_W-1]}}, a4};
        s  = (e0 <<< 1) + e1 - e3 - (e4 <<< 1);
        return DATA_W'(s >>> DERIV_SHIFT);
    endfunction

    function automatic logic [W_SQ-1:0] square(input logic signed [DATA_W-1:0] d);
        logic signed [2*DATA_W-1:0] de;
        de = {{DATA_W{d[DATA_W-1]}}, d};
        return W_SQ'(de * de);
    endfunction

    fsm_state_e               r_state, w_state_nxt;
    logic signed [DATA_W-1:0] r_x0, r_x1, r_x2, r_x3, r_x4;
    logic signed [DATA_W-1:0] r_d;
    logic [W_SQ-1:0]          r_sq;
    logic [W_ACC-1:0]         r_acc;
    logic [OUT_W-1:0]         r_tdata;
    logic                     r_tvalid;

    logic [W_SQ-1:0]  w_oldest;
    logic [W_ACC-1:0] w_acc_nxt;
    logic             w_in_hs;
    logic             w_out_hs;
    logic             w_buf_we;

    assign s_axis_tready = (r_state == IDLE) && !rst;
    assign w_in_hs       = s_axis_tvalid && s_axis_tready;
    assign w_out_hs      = r_tvalid && m_axis_tready;
    assign w_buf_we      = (r_state == INTEG);
    assign w_acc_nxt     = r_acc + {{WIN_LOG2{1'b0}}, r_sq} - {{WIN_LOG2{1'b0}}, w_oldest};
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;

    mwi_ring_buf #(
        .WIDTH     (W_SQ),
        .DEPTH_LOG2(WIN_LOG2)
    ) u_ring_buf (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_buf_we),
        .i_wdata (r_sq),
        .o_oldest(w_oldest)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_in_hs) w_state_nxt = DERIV;
            DERIV:   w_state_nxt = SQUARE;
            SQUARE:  w_state_nxt = INTEG;
            INTEG:   w_state_nxt = OUT;
            OUT:     if (w_out_hs) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x0     <= '0;
            r_x1     <= '0;
            r_x2     <= '0;
            r_x3     <= '0;
            r_x4     <= '0;
            r_d      <= '0;
            r_sq     <= '0;
            r_acc    <= '0;
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
        end else begin
            if (w_in_hs) begin
                r_x0 <= s_axis_tdata;
                r_x1 <= r_x0;
                r_x2 <= r_x1;
                r_x3 <= r_x2;
                r_x4 <= r_x3;
            end
            if (r_state == DERIV) begin
                r_d <= deriv5(r_x0, r_x1, r_x3, r_x4);
            end
            if (r_state == SQUARE) begin
                r_sq <= square(r_d);
            end
            if (r_state == INTEG) begin
                r_acc <= w_acc_nxt;
            end
            // Output register loads on the first OUT cycle, then holds until accepted.
            if ((r_state == OUT) && !r_tvalid) begin
                r_tdata  <= {{(OUT_W - W_SQ){1'b0}}, r_acc[W_ACC-1:WIN_LOG2]};
                r_tvalid <= 1'b1;
            end else if (w_out_hs) begin
                r_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ecg_qrs_feature_axis.sv
// Directed bench for ecg_qrs_feature_axis with an independent Pan-Tompkins model.
module tb_ecg_qrs_feature_axis;

    logic               clk;
    logic               rst;
    logic signed [15:0] s_axis_tdata;
    logic               s_axis_tvalid;
    logic               s_axis_tready;
    logic [31:0]        m_axis_tdata;
    logic               m_axis_tvalid;
    logic               m_axis_tready;

    int checks;
    int errors;

    longint mx  [5];
    longint msq [32];
    int     mi;

    ecg_qrs_feature_axis dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 5; i++) mx[i] = 0;
        for (int i = 0; i < 32; i++) msq[i] = 0;
        mi = 0;
    endfunction

    // Floor-division derivative, explicit 32-entry window sum, divide by 32.
    function automatic longint model_step(input int x);
        longint num, d, s;
        for (int i = 4; i > 0; i--) mx[i] = mx[i-1];
        mx[0] = longint'(x);
        num = 2 * mx[0] + mx[1] - mx[3] - 2 * mx[4];
        if (num >= 0) d = num / 8;
        else          d = -((-num + 7) / 8);
        msq[mi] = d * d;
        mi = (mi + 1) % 32;
        s = 0;
        for (int i = 0; i < 32; i++) s += msq[i];
        return s / 32;
    endfunction

    function automatic longint imp_exp(input int n);
        if (n == 1)       return 2096640;
        else if (n <= 3)  return 2620672;
        else if (n == 4)  return 3144960;
        else if (n <= 32) return 5242112;
        else              return 3145472;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic send(input int x);
        int n;
        n = 0;
        while (s_axis_tready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("send_timeout", 64'(s_axis_tready), 64'd1);
        s_axis_tdata  = 16'(x);
        s_axis_tvalid = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
    endtask

    task automatic get(input string tag, input longint exp);
        int n;
        n = 0;
        while (m_axis_tvalid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'd4);
        chk(tag, 64'(m_axis_tdata), 64'(exp));
        if (m_axis_tready) begin
            tick();
            chk({tag, "_drop"}, 64'(m_axis_tvalid), 64'd0);
        end
    endtask

    task automatic run_impulse(input string pfx);
        for (int n = 1; n <= 33; n++) begin
            send((n == 1) ? 32767 : 0);
            get(pfx, imp_exp(n));
        end
    endtask

    initial begin
        longint e;
        int     x;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b1;
        model_reset();

        // Reset state
        repeat (3) tick();
        chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_m_tdata",  64'(m_axis_tdata),  64'd0);
        chk("rst_s_tready", 64'(s_axis_tready), 64'd0);
        rst = 1'b0;
        tick();
        chk("rel_s_tready", 64'(s_axis_tready), 64'd1);

        // Full-scale impulse
        run_impulse("imp");

        // DC step of 1000
        do_reset();
        for (int n = 1; n <= 40; n++) begin
            e = model_step(1000);
            if (n == 1)       e = 1953;
            else if (n == 2)  e = 6347;
            else if (n == 3)  e = 10742;
            else if (n == 4)  e = 12695;
            else if (n >= 36) e = 0;
            send(1000);
            get("dc", e);
        end

        // Output back-pressure with a pending input
        do_reset();
        send(4000);
        get("bp_pre", model_step(4000));
        m_axis_tready = 1'b0;
        send(-7000);
        e = model_step(-7000);
        get("bp_out", e);
        s_axis_tdata  = 16'(12345);
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_tvalid",   64'(m_axis_tvalid), 64'd1);
            chk("bp_hold",     64'(m_axis_tdata),  64'(e));
            chk("bp_s_tready", 64'(s_axis_tready), 64'd0);
        end
        m_axis_tready = 1'b1;
        tick();
        chk("bp_done",       64'(m_axis_tvalid), 64'd0);
        chk("bp_idle_ready", 64'(s_axis_tready), 64'd1);
        tick();
        s_axis_tvalid = 1'b0;
        chk("bp_accept", 64'(s_axis_tready), 64'd0);
        get("bp_next", model_step(12345));
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("bp_nodup", 64'(m_axis_tvalid), 64'd0);
        end

        // Random full-scale samples across several window wraps
        do_reset();
        for (int n = 0; n < 100; n++) begin
            if (n % 7 == 3)      x = 32767;
            else if (n % 7 == 5) x = -32768;
            else                 x = int'($urandom_range(0, 65535)) - 32768;
            send(x);
            get("rand", model_step(x));
        end

        // Reset while the accumulator update is in progress
        do_reset();
        send(32767);
        get("mo_pre", model_step(32767));
        send(-20000);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("mo_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("mo_tdata",  64'(m_axis_tdata),  64'd0);
        chk("mo_tready", 64'(s_axis_tready), 64'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("mo_quiet", 64'(m_axis_tvalid), 64'd0);
        end
        model_reset();
        run_impulse("rerun");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
